// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline definitions for the mem_stage slice.
//   XLEN_DEFAULT  : default datapath width
//   MB_*          : bit positions inside the EX/MEM mBuffer control field
//   WB_*          : bit positions inside the wbBuffer control field
//   mem_state_e   : memory stage FSM states
//   memwb_ctrl_t  : control portion of the MEM/WB register
package riscv_pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    localparam int unsigned MB_BRANCH   = 2;
    localparam int unsigned MB_MEMREAD  = 1;
    localparam int unsigned MB_MEMWRITE = 0;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] wb;
        logic       mem_err;
    } memwb_ctrl_t;

    // Keep MemtoReg, clear RegWrite so an aborted load never writes the register file.
    function automatic logic [1:0] wb_kill_regwrite(input logic [1:0] wb);
        logic [1:0] r;
        r              = '0;
        r[WB_MEMTOREG] = wb[WB_MEMTOREG];
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: request/acknowledge bus between the memory stage and data memory.
//   req, we       : request and write enable (master -> slave)
//   addr, wdata   : address and store data, stable while req=1 (master -> slave)
//   rdata         : load data, valid only while ack=1 (slave -> master)
//   ack           : transaction complete (slave -> master)
interface mem_stage_if
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/memwb_reg.sv
// memwb_reg: MEM/WB pipeline register.
//   clk, reset        : clock, asynchronous active-high reset (clears to a bubble)
//   load_data         : capture read_data_d / alu_result_d / ctrl_d
//   load_bubble       : capture an all-zero bubble (load_data has priority)
//   read_data_q, alu_result_q, ctrl_q : registered MEM/WB contents
// With neither load input asserted the register holds its value.
module memwb_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_bubble,
    input  logic            load_data,
    input  logic [XLEN-1:0] read_data_d,
    input  logic [XLEN-1:0] alu_result_d,
    input  memwb_ctrl_t     ctrl_d,
    output logic [XLEN-1:0] read_data_q,
    output logic [XLEN-1:0] alu_result_q,
    output memwb_ctrl_t     ctrl_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            ctrl_q       <= '0;
        end else if (load_data) begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            ctrl_q       <= ctrl_d;
        end else if (load_bubble) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            ctrl_q       <= '0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage RISC-V pipeline.
// Resolves the branch, runs a req/ack data memory transaction for loads and
// stores while stalling upstream, and loads the MEM/WB register.
//   clk, reset                      : clock, asynchronous active-high reset
//   ex_valid, zero_in, branch_in,
//   aluResult_in, forwardB_in, rd_in,
//   mBuffer_in, wbBuffer_in         : EX/MEM bundle
//   pcSrc, branchTarget_out         : branch decision (combinational)
//   stall                           : hold upstream registers (combinational)
//   dmem                            : data memory bus (mem_stage_if.master)
//   readData_out, aluResult_out,
//   rd_out, wbBuffer_out, memErr_out: MEM/WB register
// Optional feature macro: MEM_STAGE_TIMEOUT_EN aborts an access after TIMEOUT
// cycles without ack; otherwise the stage waits for ack indefinitely.
module mem_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             zero_in,
    input  logic [XLEN-1:0]  branch_in,
    input  logic [XLEN-1:0]  aluResult_in,
    input  logic [XLEN-1:0]  forwardB_in,
    input  logic [4:0]       rd_in,
    input  logic [2:0]       mBuffer_in,
    input  logic [1:0]       wbBuffer_in,
    output logic             pcSrc,
    output logic [XLEN-1:0]  branchTarget_out,
    output logic             stall,
    mem_stage_if.master      dmem,
    output logic [XLEN-1:0]  readData_out,
    output logic [XLEN-1:0]  aluResult_out,
    output logic [4:0]       rd_out,
    output logic [1:0]       wbBuffer_out,
    output logic             memErr_out
);

    localparam logic [0:0] ST_IDLE   = 1'(S_IDLE);
    localparam logic [0:0] ST_ACCESS = 1'(S_ACCESS);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("mem_stage: TIMEOUT must be at least 1");
    end

    logic [0:0]      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      wbb_q, wbb_d;

    logic            memop_c;
    logic            timeout_hit_c;
    logic            stall_c;

    logic            wb_load_data;
    logic            wb_load_bubble;
    logic [XLEN-1:0] wb_rdata_d;
    logic [XLEN-1:0] wb_alu_d;
    memwb_ctrl_t     wb_ctrl_d;
    memwb_ctrl_t     wb_ctrl_q;

    // Branch resolution is independent of the memory FSM.
    assign pcSrc            = mBuffer_in[MB_BRANCH] & zero_in & ex_valid;
    assign branchTarget_out = branch_in;

    assign memop_c = ex_valid & (mBuffer_in[MB_MEMREAD] | mBuffer_in[MB_MEMWRITE]);

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts ACCESS cycles without ack; cleared when a new access is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE && memop_c) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !dmem.ack) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit_c = (state_q == ST_ACCESS) & ~dmem.ack
                         & (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Next-state, bus latch and MEM/WB load control.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_d           = rd_q;
        wbb_d          = wbb_q;
        stall_c        = 1'b0;
        wb_load_data   = 1'b0;
        wb_load_bubble = 1'b0;
        wb_rdata_d     = '0;
        wb_alu_d       = '0;
        wb_ctrl_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (memop_c) begin
                    // Launch: latch the bundle, it is not sampled again until ack.
                    stall_c        = 1'b1;
                    state_d        = ST_ACCESS;
                    req_d          = 1'b1;
                    we_d           = mBuffer_in[MB_MEMWRITE];
                    addr_d         = aluResult_in;
                    wdata_d        = forwardB_in;
                    rd_d           = rd_in;
                    wbb_d          = wbBuffer_in;
                    wb_load_bubble = 1'b1;
                end else if (ex_valid) begin
                    wb_load_data   = 1'b1;
                    wb_alu_d       = aluResult_in;
                    wb_ctrl_d.rd   = rd_in;
                    wb_ctrl_d.wb   = wbBuffer_in;
                end else begin
                    wb_load_bubble = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (dmem.ack) begin
                    // Write wins when both MemRead and MemWrite are set.
                    state_d        = ST_IDLE;
                    req_d          = 1'b0;
                    wb_load_data   = 1'b1;
                    wb_rdata_d     = we_q ? '0 : dmem.rdata;
                    wb_alu_d       = addr_q;
                    wb_ctrl_d.rd   = rd_q;
                    wb_ctrl_d.wb   = wbb_q;
                end else if (timeout_hit_c) begin
                    state_d           = ST_IDLE;
                    req_d             = 1'b0;
                    wb_load_data      = 1'b1;
                    wb_alu_d          = addr_q;
                    wb_ctrl_d.rd      = rd_q;
                    wb_ctrl_d.wb      = wb_kill_regwrite(wbb_q);
                    wb_ctrl_d.mem_err = 1'b1;
                end else begin
                    stall_c        = 1'b1;
                    wb_load_bubble = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and bus latches; reset drops dmem_req immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            wbb_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wbb_q   <= wbb_d;
        end
    end

    assign stall      = stall_c;
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    memwb_reg #(
        .XLEN (XLEN)
    ) u_memwb (
        .clk          (clk),
        .reset        (reset),
        .load_bubble  (wb_load_bubble),
        .load_data    (wb_load_data),
        .read_data_d  (wb_rdata_d),
        .alu_result_d (wb_alu_d),
        .ctrl_d       (wb_ctrl_d),
        .read_data_q  (readData_out),
        .alu_result_q (aluResult_out),
        .ctrl_q       (wb_ctrl_q)
    );

    assign rd_out       = wb_ctrl_q.rd;
    assign wbBuffer_out = wb_ctrl_q.wb;
    assign memErr_out   = wb_ctrl_q.mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_stage;
    import riscv_pipe_pkg::*;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            reset;
    logic            ex_valid;
    logic            zero_in;
    logic [XLEN-1:0] branch_in;
    logic [XLEN-1:0] aluResult_in;
    logic [XLEN-1:0] forwardB_in;
    logic [4:0]      rd_in;
    logic [2:0]      mBuffer_in;
    logic [1:0]      wbBuffer_in;
    logic            pcSrc;
    logic [XLEN-1:0] branchTarget_out;
    logic            stall;
    logic [XLEN-1:0] readData_out;
    logic [XLEN-1:0] aluResult_out;
    logic [4:0]      rd_out;
    logic [1:0]      wbBuffer_out;
    logic            memErr_out;

    int n_checks;
    int n_errors;
    int stall_cycles;

    mem_stage_if #(.XLEN(XLEN)) dmem_bus ();

    mem_stage #(
        .XLEN    (XLEN),
        .TIMEOUT (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .zero_in          (zero_in),
        .branch_in        (branch_in),
        .aluResult_in     (aluResult_in),
        .forwardB_in      (forwardB_in),
        .rd_in            (rd_in),
        .mBuffer_in       (mBuffer_in),
        .wbBuffer_in      (wbBuffer_in),
        .pcSrc            (pcSrc),
        .branchTarget_out (branchTarget_out),
        .stall            (stall),
        .dmem             (dmem_bus),
        .readData_out     (readData_out),
        .aluResult_out    (aluResult_out),
        .rd_out           (rd_out),
        .wbBuffer_out     (wbBuffer_out),
        .memErr_out       (memErr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid       = 1'b0;
        zero_in        = 1'b0;
        branch_in      = '0;
        aluResult_in   = '0;
        forwardB_in    = '0;
        rd_in          = '0;
        mBuffer_in     = '0;
        wbBuffer_in    = '0;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = '0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata} !== {2'b00, 64'h0, 64'h0}) begin
            n_errors++;
            $display("FAIL reset_bus: got req=%0b we=%0b addr=%0h wdata=%0h expected all 0",
                     dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata);
        end
        n_checks++;
        if ({readData_out, aluResult_out, rd_out, wbBuffer_out, memErr_out} !== 136'h0) begin
            n_errors++;
            $display("FAIL reset_memwb: got rdata=%0h alu=%0h rd=%0d wb=%0b err=%0b expected all 0",
                     readData_out, aluResult_out, rd_out, wbBuffer_out, memErr_out);
        end
        n_checks++;
        if ({stall, pcSrc} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_comb: got stall=%0b pcSrc=%0b expected 0 0", stall, pcSrc);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_op();
        tick();
        ex_valid     = 1'b1;
        mBuffer_in   = 3'b000;
        rd_in        = 5'd5;
        aluResult_in = 64'h10;
        wbBuffer_in  = 2'b10;
        dmem_bus.ack = 1'b1;   // ack while idle must be ignored
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_stall: got %0b expected 0", stall);
        end
        tick();
        n_checks++;
        if ({aluResult_out, rd_out, wbBuffer_out, readData_out, memErr_out} !==
            {64'h10, 5'd5, 2'b10, 64'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL alu_memwb: got alu=%0h rd=%0d wb=%0b rdata=%0h err=%0b expected 10 5 10 0 0",
                     aluResult_out, rd_out, wbBuffer_out, readData_out, memErr_out);
        end
        n_checks++;
        if ({dmem_bus.req, stall} !== 2'b00) begin
            n_errors++;
            $display("FAIL alu_idle_ack: got req=%0b stall=%0b expected 0 0", dmem_bus.req, stall);
        end
        // Invalid bundle must produce a bubble.
        ex_valid     = 1'b0;
        dmem_bus.ack = 1'b0;
        aluResult_in = 64'h77;
        rd_in        = 5'd9;
        wbBuffer_in  = 2'b11;
        tick();
        n_checks++;
        if ({aluResult_out, rd_out, wbBuffer_out} !== 71'h0) begin
            n_errors++;
            $display("FAIL invalid_bubble: got alu=%0h rd=%0d wb=%0b expected 0 0 0",
                     aluResult_out, rd_out, wbBuffer_out);
        end
        clear_inputs();
    endtask

    task automatic test_load();
        stall_cycles = 0;
        ex_valid     = 1'b1;
        mBuffer_in   = 3'b010;
        aluResult_in = 64'h100;
        forwardB_in  = 64'h55;
        rd_in        = 5'd7;
        wbBuffer_in  = 2'b11;
        #1;
        if (stall === 1'b1) stall_cycles++;
        tick();
        n_checks++;
        if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr} !== {1'b1, 1'b0, 64'h100}) begin
            n_errors++;
            $display("FAIL load_req: got req=%0b we=%0b addr=%0h expected 1 0 100",
                     dmem_bus.req, dmem_bus.we, dmem_bus.addr);
        end
        n_checks++;
        if ({rd_out, wbBuffer_out, readData_out} !== 71'h0) begin
            n_errors++;
            $display("FAIL load_bubble: got rd=%0d wb=%0b rdata=%0h expected 0 0 0",
                     rd_out, wbBuffer_out, readData_out);
        end
        // Bundle inputs change during the access; the latched copies must be used.
        aluResult_in = 64'hBAD;
        rd_in        = 5'd3;
        mBuffer_in   = 3'b000;
        #1;
        if (stall === 1'b1) stall_cycles++;
        tick();
        n_checks++;
        if ({dmem_bus.req, dmem_bus.addr} !== {1'b1, 64'h100}) begin
            n_errors++;
            $display("FAIL load_hold: got req=%0b addr=%0h expected 1 100", dmem_bus.req, dmem_bus.addr);
        end
        if (stall === 1'b1) stall_cycles++;
        tick();
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 64'hDEAD;
        #1;
        if (stall === 1'b1) stall_cycles++;
        n_checks++;
        if (stall_cycles !== 3) begin
            n_errors++;
            $display("FAIL load_stall_cycles: got %0d expected 3", stall_cycles);
        end
        tick();
        ex_valid     = 1'b0;
        dmem_bus.ack = 1'b0;
        n_checks++;
        if ({readData_out, aluResult_out, rd_out, wbBuffer_out, dmem_bus.req} !==
            {64'hDEAD, 64'h100, 5'd7, 2'b11, 1'b0}) begin
            n_errors++;
            $display("FAIL load_result: got rdata=%0h alu=%0h rd=%0d wb=%0b req=%0b expected dead 100 7 11 0",
                     readData_out, aluResult_out, rd_out, wbBuffer_out, dmem_bus.req);
        end
        clear_inputs();
    endtask

    task automatic test_store();
        ex_valid     = 1'b1;
        mBuffer_in   = 3'b001;
        aluResult_in = 64'h200;
        forwardB_in  = 64'hBEEF;
        rd_in        = 5'd4;
        wbBuffer_in  = 2'b00;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL store_stall_launch: got %0b expected 1", stall);
        end
        tick();
        n_checks++;
        if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata} !== {2'b11, 64'h200, 64'hBEEF}) begin
            n_errors++;
            $display("FAIL store_req: got req=%0b we=%0b addr=%0h wdata=%0h expected 1 1 200 beef",
                     dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata);
        end
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 64'h1234;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL store_stall_ack: got %0b expected 0", stall);
        end
        tick();
        ex_valid     = 1'b0;
        dmem_bus.ack = 1'b0;
        n_checks++;
        if ({readData_out, aluResult_out, rd_out, dmem_bus.req} !== {64'h0, 64'h200, 5'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL store_result: got rdata=%0h alu=%0h rd=%0d req=%0b expected 0 200 4 0",
                     readData_out, aluResult_out, rd_out, dmem_bus.req);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        ex_valid   = 1'b1;
        mBuffer_in = 3'b100;
        zero_in    = 1'b1;
        branch_in  = 64'h40;
        #1;
        n_checks++;
        if ({pcSrc, branchTarget_out, stall} !== {1'b1, 64'h40, 1'b0}) begin
            n_errors++;
            $display("FAIL branch_taken: got pcSrc=%0b target=%0h stall=%0b expected 1 40 0",
                     pcSrc, branchTarget_out, stall);
        end
        zero_in = 1'b0;
        #1;
        n_checks++;
        if (pcSrc !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_not_zero: got %0b expected 0", pcSrc);
        end
        zero_in  = 1'b1;
        ex_valid = 1'b0;
        #1;
        n_checks++;
        if (pcSrc !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_invalid: got %0b expected 0", pcSrc);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        ex_valid     = 1'b1;
        mBuffer_in   = 3'b010;
        aluResult_in = 64'h300;
        rd_in        = 5'd8;
        wbBuffer_in  = 2'b11;
        tick();
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 64'hCAFE;
        tick();
        n_checks++;
        if ({readData_out, rd_out, dmem_bus.req} !== {64'hCAFE, 5'd8, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_first: got rdata=%0h rd=%0d req=%0b expected cafe 8 0",
                     readData_out, rd_out, dmem_bus.req);
        end
        // Second memop with both MemRead and MemWrite: the write wins.
        dmem_bus.ack = 1'b0;
        mBuffer_in   = 3'b011;
        aluResult_in = 64'h308;
        forwardB_in  = 64'h99;
        rd_in        = 5'd9;
        wbBuffer_in  = 2'b10;
        #1;
        n_checks++;
        if ({stall, dmem_bus.req} !== 2'b10) begin
            n_errors++;
            $display("FAIL b2b_gap: got stall=%0b req=%0b expected 1 0", stall, dmem_bus.req);
        end
        tick();
        n_checks++;
        if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata} !== {2'b11, 64'h308, 64'h99}) begin
            n_errors++;
            $display("FAIL b2b_second_req: got req=%0b we=%0b addr=%0h wdata=%0h expected 1 1 308 99",
                     dmem_bus.req, dmem_bus.we, dmem_bus.addr, dmem_bus.wdata);
        end
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 64'hFFFF;
        tick();
        ex_valid     = 1'b0;
        dmem_bus.ack = 1'b0;
        n_checks++;
        if ({readData_out, aluResult_out, rd_out, wbBuffer_out} !== {64'h0, 64'h308, 5'd9, 2'b10}) begin
            n_errors++;
            $display("FAIL b2b_second_result: got rdata=%0h alu=%0h rd=%0d wb=%0b expected 0 308 9 10",
                     readData_out, aluResult_out, rd_out, wbBuffer_out);
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_access();
        // Put a real value in MEM/WB first so the reset clear is observable.
        ex_valid     = 1'b1;
        aluResult_in = 64'h44;
        rd_in        = 5'd2;
        wbBuffer_in  = 2'b10;
        tick();
        mBuffer_in   = 3'b010;
        aluResult_in = 64'h400;
        rd_in        = 5'd1;
        tick();
        ex_valid   = 1'b0;
        mBuffer_in = 3'b000;
        n_checks++;
        if ({dmem_bus.req, dmem_bus.addr} !== {1'b1, 64'h400}) begin
            n_errors++;
            $display("FAIL rst_access_pre: got req=%0b addr=%0h expected 1 400", dmem_bus.req, dmem_bus.addr);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({dmem_bus.req, dmem_bus.we, dmem_bus.addr, readData_out, aluResult_out,
             rd_out, wbBuffer_out, memErr_out} !== 202'h0) begin
            n_errors++;
            $display("FAIL rst_access_clear: got req=%0b addr=%0h alu=%0h rd=%0d wb=%0b expected all 0",
                     dmem_bus.req, dmem_bus.addr, aluResult_out, rd_out, wbBuffer_out);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        dmem_bus.ack   = 1'b1;
        dmem_bus.rdata = 64'h5;
        tick();
        dmem_bus.ack = 1'b0;
        #1;
        n_checks++;
        if ({dmem_bus.req, stall, readData_out, wbBuffer_out} !== 68'h0) begin
            n_errors++;
            $display("FAIL rst_late_ack: got req=%0b stall=%0b rdata=%0h wb=%0b expected 0 0 0 0",
                     dmem_bus.req, stall, readData_out, wbBuffer_out);
        end
        clear_inputs();
        tick();
    endtask

`ifdef MEM_STAGE_TIMEOUT_EN
    task automatic test_timeout();
        ex_valid     = 1'b1;
        mBuffer_in   = 3'b010;
        aluResult_in = 64'h500;
        rd_in        = 5'd6;
        wbBuffer_in  = 2'b11;
        tick();
        ex_valid   = 1'b0;
        mBuffer_in = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            n_checks++;
            if ({stall, dmem_bus.req} !== {(i < 4), 1'b1}) begin
                n_errors++;
                $display("FAIL timeout_cycle%0d: got stall=%0b req=%0b expected %0b 1",
                         i, stall, dmem_bus.req, (i < 4));
            end
        end
        tick();
        n_checks++;
        if ({memErr_out, wbBuffer_out, readData_out, aluResult_out, rd_out, dmem_bus.req} !==
            {1'b1, 2'b01, 64'h0, 64'h500, 5'd6, 1'b0}) begin
            n_errors++;
            $display("FAIL timeout_abort: got err=%0b wb=%0b rdata=%0h alu=%0h rd=%0d req=%0b expected 1 01 0 500 6 0",
                     memErr_out, wbBuffer_out, readData_out, aluResult_out, rd_out, dmem_bus.req);
        end
        tick();
        n_checks++;
        if ({memErr_out, stall} !== 2'b00) begin
            n_errors++;
            $display("FAIL timeout_after: got err=%0b stall=%0b expected 0 0", memErr_out, stall);
        end
        clear_inputs();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_branch();
        test_back_to_back();
        test_reset_in_access();
`ifdef MEM_STAGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
